// File: rtl/sm_subtractor_pipe.sv
// Two-stage pipelined sign-magnitude subtractor (out = a - b) with valid/ready
// handshake, magnitude saturation with overflow flag, and negative-zero suppression.
module sm_subtractor_pipe #(
    parameter int size = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [size-1:0] a,
    input  logic [size-1:0] b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [size-1:0] out,
    output logic            ovf
);

    localparam int MW = size - 1;

    logic [MW-1:0] mag_a;
    logic [MW-1:0] mag_b;
    logic          sign_a;
    logic          sign_bn;
    logic          a_gt_b;
    logic          in_fire;
    logic          s2_load;

    logic          s1_v_reg;
    logic [MW-1:0] s1_max_reg;
    logic [MW-1:0] s1_min_reg;
    logic          s1_sign_reg;
    logic          s1_add_reg;

    logic          s2_v_reg;
    logic [MW-1:0] s2_mag_reg;
    logic          s2_sign_reg;
    logic          s2_ovf_reg;

    logic [MW:0]   sum_next;
    logic [MW-1:0] mag_next;
    logic          sign_next;
    logic          ovf_next;

    // Subtraction is addition of b with its sign flipped.
    assign mag_a   = a[MW-1:0];
    assign mag_b   = b[MW-1:0];
    assign sign_a  = a[MW];
    assign sign_bn = ~b[MW];
    assign a_gt_b  = (mag_a > mag_b);

    assign s2_load  = !s2_v_reg || out_ready;
    assign in_ready = !s1_v_reg || s2_load;
    assign in_fire  = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v_reg    <= 1'b0;
            s1_max_reg  <= '0;
            s1_min_reg  <= '0;
            s1_sign_reg <= 1'b0;
            s1_add_reg  <= 1'b0;
        end else begin
            if (in_fire) begin
                s1_v_reg    <= 1'b1;
                s1_max_reg  <= a_gt_b ? mag_a : mag_b;
                s1_min_reg  <= a_gt_b ? mag_b : mag_a;
                s1_sign_reg <= a_gt_b ? sign_a : sign_bn;
                s1_add_reg  <= (sign_a == sign_bn);
            end else if (s2_load) begin
                s1_v_reg <= 1'b0;
            end
        end
    end

    // max >= min, so the subtract path can never borrow out of the top bit.
    always_comb begin
        sum_next  = '0;
        mag_next  = '0;
        sign_next = 1'b0;
        ovf_next  = 1'b0;
        if (s1_add_reg) begin
            sum_next = {1'b0, s1_max_reg} + {1'b0, s1_min_reg};
            ovf_next = sum_next[MW];
        end else begin
            sum_next = {1'b0, s1_max_reg} - {1'b0, s1_min_reg};
        end
        mag_next  = ovf_next ? {MW{1'b1}} : sum_next[MW-1:0];
        sign_next = (mag_next != '0) ? s1_sign_reg : 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_v_reg    <= 1'b0;
            s2_mag_reg  <= '0;
            s2_sign_reg <= 1'b0;
            s2_ovf_reg  <= 1'b0;
        end else if (s2_load) begin
            s2_v_reg <= s1_v_reg;
            if (s1_v_reg) begin
                s2_mag_reg  <= mag_next;
                s2_sign_reg <= sign_next;
                s2_ovf_reg  <= ovf_next;
            end
        end
    end

    assign out_valid = s2_v_reg;
    assign out       = {s2_sign_reg, s2_mag_reg};
    assign ovf       = s2_ovf_reg;

endmodule
